mult_div_unit: RTL

//  Iterative multiply/divide execute stage. Sits directly downstream of the

---
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide execute stage: M-step shift-add multiply or restoring
// divide on operand magnitudes, followed by a sign fix-up and a one-cycle DONE.
module mult_div_unit #(
  parameter int M = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [1:0]   OP,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [M-1:0] HI,
  output logic [M-1:0] LO,
  output logic         DIVZ
);

  localparam int CW = $clog2(M);
  localparam int W2 = 2 * M;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_FIN
  } state_e;

  // Magnitude of a two's-complement value; MIN_INT maps to unsigned 2^(M-1).
  function automatic logic [M-1:0] magnitude(input logic signed [M-1:0] v,
                                             input logic use_sign);
    if (use_sign && v[M-1]) return ~v + M'(1);
    return v;
  endfunction

  function automatic logic [M-1:0] cond_neg(input logic [M-1:0] v, input logic neg);
    return neg ? (~v + M'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] cond_neg_w(input logic [W2-1:0] v, input logic neg);
    return neg ? (~v + W2'(1)) : v;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [M-1:0]    ma_q, ma_d;
  logic [M-1:0]    mb_q, mb_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            sign_a_q, sign_a_d;
  logic            divz_q, divz_d;
  logic [M-1:0]    hi_q, hi_d;
  logic [M-1:0]    lo_q, lo_d;
  logic            divz_o_q, divz_o_d;

  logic            op_signed;
  logic [M-1:0]    a_mag, b_mag;
  logic [M:0]      add_sum;
  logic [W2-1:0]   mul_step;
  logic [M:0]      div_shift;
  logic [M+1:0]    div_diff;
  logic [W2-1:0]   div_step;
  logic [W2-1:0]   prod_fix;
  logic [M-1:0]    fix_hi, fix_lo;

  assign op_signed = ~OP[0];
  assign a_mag     = magnitude(A, op_signed);
  assign b_mag     = magnitude(B, op_signed);

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  assign add_sum  = {1'b0, acc_q[W2-1:M]} + (acc_q[0] ? {1'b0, ma_q} : {(M+1){1'b0}});
  assign mul_step = {add_sum, acc_q[M-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}; shift left, trial subtract.
  assign div_shift = {acc_q[W2-1:M], acc_q[M-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mb_q};
  assign div_step  = div_diff[M+1] ? {div_shift[M-1:0], acc_q[M-2:0], 1'b0}
                                   : {div_diff[M-1:0],  acc_q[M-2:0], 1'b1};

  // Sign fix-up; remainder follows the dividend, which for B==0 reproduces A exactly.
  assign prod_fix = cond_neg_w(acc_q, neg_res_q);

  always_comb begin
    fix_hi = prod_fix[W2-1:M];
    fix_lo = prod_fix[M-1:0];
    if (is_div_q) begin
      fix_hi = cond_neg(acc_q[W2-1:M], sign_a_q);
      fix_lo = divz_q ? {M{1'b1}} : cond_neg(acc_q[M-1:0], neg_res_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    sign_a_d  = sign_a_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divz_o_d  = divz_o_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          is_div_d  = OP[1];
          ma_d      = a_mag;
          mb_d      = b_mag;
          sign_a_d  = op_signed & A[M-1];
          neg_res_d = op_signed & (A[M-1] ^ B[M-1]);
          divz_d    = OP[1] & (B == '0);
          acc_d     = OP[1] ? {{M{1'b0}}, a_mag} : {{M{1'b0}}, b_mag};
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(M - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d     = fix_hi;
        lo_d     = fix_lo;
        divz_o_d = is_div_q & divz_q;
        state_d  = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      sign_a_q  <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      divz_o_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      sign_a_q  <= sign_a_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divz_o_q  <= divz_o_d;
    end
  end

  assign BUSY = (state_q != S_IDLE);
  assign DONE = (state_q == S_FIN);
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign DIVZ = divz_o_q;

endmodule
